l2_flush_walker: RTL and testbench

//  Sequences a whole-cache L2 flush: walks every (set, way) of the tag/state arrays,

---
 rtl/l2_flush_walker.sv | 120 ++++++++++++
 tb/tb_l2_flush_walker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_flush_walker.sv
// Whole-cache L2 flush sequencer: walks every (set, way), evicts valid lines
// through request-out, then invalidates the state entry. Yields to 'hold' before each read.
//
// state   | meaning
// IDLE    | waiting for a flush request, flush_ready high
// READ    | issue one read of state/hprot at (rd_set, rd_way); stalls while hold
// CHECK   | read data valid; decide skip or evict, capture dirty
// EVICT   | evict_valid held until evict_ready
// INVAL   | write INVALID into the current entry
// NEXT    | advance way (inner) / set (outer), or finish on the last entry
// DONE    | one-cycle completion pulse
module l2_flush_walker #(
  parameter int SET_BITS = 8,
  parameter int WAY_BITS = 3,
  parameter int ST_W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_valid,
  output logic                       flush_ready,
  input  logic                       flush_all,
  input  logic                       hold,
  output logic                       rd_en,
  output logic [SET_BITS-1:0]        rd_set,
  output logic [WAY_BITS-1:0]        rd_way,
  input  logic [ST_W-1:0]            rd_state,
  input  logic                       rd_hprot,
  output logic                       evict_valid,
  input  logic                       evict_ready,
  output logic                       evict_dirty,
  output logic                       wr_state_en,
  output logic                       busy,
  output logic                       flush_done,
  output logic [SET_BITS+WAY_BITS:0] evict_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_EVICT = 3'd3;
  localparam logic [2:0] S_INVAL = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [ST_W-1:0] ST_INVALID  = '0;
  localparam logic [ST_W-1:0] ST_MODIFIED = ST_W'(3);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       flush_all_q;
  logic       skip;
  logic       last_entry;

  // Instruction lines (hprot=0) are kept unless the flush covers everything.
  assign skip       = (rd_state == ST_INVALID) || (!flush_all_q && !rd_hprot);
  assign last_entry = (&rd_way) && (&rd_set);

  assign flush_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rd_en       = (state_q == S_READ) && !hold;
  assign evict_valid = (state_q == S_EVICT);
  assign wr_state_en = (state_q == S_INVAL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush_valid) state_d = S_READ;
      S_READ:  if (!hold) state_d = S_CHECK;
      S_CHECK: state_d = skip ? S_NEXT : S_EVICT;
      S_EVICT: if (evict_ready) state_d = S_INVAL;
      S_INVAL: state_d = S_NEXT;
      S_NEXT:  state_d = last_entry ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      flush_all_q <= 1'b0;
      rd_set      <= '0;
      rd_way      <= '0;
      evict_dirty <= 1'b0;
      evict_cnt   <= '0;
      flush_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_done <= (state_q == S_NEXT) && last_entry;
      case (state_q)
        S_IDLE: begin
          if (flush_valid) begin
            flush_all_q <= flush_all;
            rd_set      <= '0;
            rd_way      <= '0;
            evict_cnt   <= '0;
          end
        end
        S_CHECK: begin
          if (!skip) evict_dirty <= (rd_state == ST_MODIFIED);
        end
        S_EVICT: begin
          if (evict_ready) evict_cnt <= evict_cnt + (SET_BITS+WAY_BITS+1)'(1);
        end
        S_NEXT: begin
          if (!last_entry) begin
            if (&rd_way) begin
              rd_way <= '0;
              rd_set <= rd_set + SET_BITS'(1);
            end else begin
              rd_way <= rd_way + WAY_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_flush_walker.sv
// Scoreboard bench for l2_flush_walker on an 8-entry cache (4 sets x 2 ways).
// Stimulus pushes expected evictions/invalidates/completions; monitors pop and compare.
module tb_l2_flush_walker;

  localparam int SB = 2;
  localparam int WB = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_valid = 1'b0;
  logic          flush_ready;
  logic          flush_all = 1'b0;
  logic          hold = 1'b0;
  logic          rd_en;
  logic [SB-1:0] rd_set;
  logic [WB-1:0] rd_way;
  logic [2:0]    rd_state = 3'd0;
  logic          rd_hprot = 1'b0;
  logic          evict_valid;
  logic          evict_ready = 1'b1;
  logic          evict_dirty;
  logic          wr_state_en;
  logic          busy;
  logic          flush_done;
  logic [SB+WB:0] evict_cnt;

  l2_flush_walker #(.SET_BITS(SB), .WAY_BITS(WB), .ST_W(3)) dut (
    .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_ready(flush_ready),
    .flush_all(flush_all), .hold(hold), .rd_en(rd_en), .rd_set(rd_set), .rd_way(rd_way),
    .rd_state(rd_state), .rd_hprot(rd_hprot), .evict_valid(evict_valid),
    .evict_ready(evict_ready), .evict_dirty(evict_dirty), .wr_state_en(wr_state_en),
    .busy(busy), .flush_done(flush_done), .evict_cnt(evict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int s; int w; int d;} ent_t;
  ent_t ev_q[$];
  ent_t inv_q[$];
  int   done_q[$];
  int   errors = 0;
  int   checks = 0;
  int   reads21 = 0;

  logic [2:0] st_mem[8];
  logic       hp_mem[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array model: one-cycle read latency, invalidate on wr_state_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_state <= st_mem[{rd_set, rd_way}];
      rd_hprot <= hp_mem[{rd_set, rd_way}];
    end
    if (wr_state_en) st_mem[{rd_set, rd_way}] = 3'd0;
  end

  always @(negedge clk) begin
    ent_t e;
    int   n;
    if (rst) begin
      if (rd_en && rd_set == 2'd2 && rd_way == 1'b1) reads21++;
      if (evict_valid && evict_ready) begin
        chk("evict_expected", int'(ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          chk("evict_set", int'(rd_set), e.s);
          chk("evict_way", int'(rd_way), e.w);
          chk("evict_dirty", int'(evict_dirty), e.d);
        end
      end
      if (wr_state_en) begin
        chk("inval_expected", int'(inv_q.size() > 0), 1);
        if (inv_q.size() > 0) begin
          e = inv_q.pop_front();
          chk("inval_set", int'(rd_set), e.s);
          chk("inval_way", int'(rd_way), e.w);
        end
      end
      if (flush_done) begin
        chk("done_expected", int'(done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          n = done_q.pop_front();
          chk("evict_cnt", int'(evict_cnt), n);
        end
      end
    end
  end

  task automatic push_ev(input int s, input int w, input int d);
    ent_t e;
    e.s = s; e.w = w; e.d = d;
    ev_q.push_back(e);
    inv_q.push_back(e);
  endtask

  // Called #1 after a posedge with the walker idle; acceptance happens at the next edge.
  task automatic start_flush(input logic all);
    flush_all   = all;
    flush_valid = 1'b1;
    @(posedge clk);
    #1 flush_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (flush_done) break;
    end
    chk("done_seen", int'(flush_done), 1);
  endtask

  task automatic wait_evict();
    int n = 0;
    while (!evict_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("evict_valid_seen", int'(evict_valid), 1);
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_ev_q_left"}, ev_q.size(), 0);
    chk({tag, "_inv_q_left"}, inv_q.size(), 0);
    chk({tag, "_done_q_left"}, done_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    for (int i = 0; i < 8; i++) begin
      st_mem[i] = 3'd0;
      hp_mem[i] = 1'b1;
    end

    // Reset values
    #12;
    chk("rst_flush_ready", int'(flush_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_evict_valid", int'(evict_valid), 0);
    chk("rst_wr_state_en", int'(wr_state_en), 0);
    chk("rst_flush_done", int'(flush_done), 0);
    chk("rst_evict_cnt", int'(evict_cnt), 0);
    chk("rst_rd_set", int'(rd_set), 0);
    chk("rst_rd_way", int'(rd_way), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: all invalid, 8 skips x 3 cycles
    done_q.push_back(0);
    start_flush(1'b1);
    chk("t1_busy", int'(busy), 1);
    chk("t1_flush_ready", int'(flush_ready), 0);
    wait_done(n);
    chk("t1_done_latency", n, 24);
    @(posedge clk); #1;
    chk("t1_idle_after_done", int'(flush_ready), 1);
    chk("t1_done_one_cycle", int'(flush_done), 0);
    queues_empty("t1");

    // 2: MODIFIED at (1,0), SHARED at (3,1)
    st_mem[2] = 3'd3;
    st_mem[7] = 3'd1;
    push_ev(1, 0, 1);
    push_ev(3, 1, 0);
    done_q.push_back(2);
    start_flush(1'b1);
    wait_done(n);
    chk("t2_latency", n, 24 + 2 * 2);
    chk("t2_mem_1_0_inval", int'(st_mem[2]), 0);
    chk("t2_mem_3_1_inval", int'(st_mem[7]), 0);
    @(posedge clk); #1;
    queues_empty("t2");

    // 3a: data-only flush skips an instruction line
    st_mem[4] = 3'd2;
    hp_mem[4] = 1'b0;
    done_q.push_back(0);
    start_flush(1'b0);
    wait_done(n);
    chk("t3a_line_kept", int'(st_mem[4]), 2);
    @(posedge clk); #1;
    // 3b: same line as data is evicted clean
    hp_mem[4] = 1'b1;
    push_ev(2, 0, 0);
    done_q.push_back(1);
    start_flush(1'b0);
    wait_done(n);
    @(posedge clk); #1;
    queues_empty("t3");

    // 4: backpressure with hold asserted during EVICT
    st_mem[3] = 3'd3;
    evict_ready = 1'b0;
    push_ev(1, 1, 1);
    done_q.push_back(1);
    start_flush(1'b1);
    wait_evict();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_evict_valid_stable", int'(evict_valid), 1);
      chk("t4_set_stable", int'(rd_set), 1);
      chk("t4_way_stable", int'(rd_way), 1);
      chk("t4_dirty_stable", int'(evict_dirty), 1);
      @(posedge clk); #1;
    end
    evict_ready = 1'b1;
    hold = 1'b0;
    wait_done(n);
    @(posedge clk); #1;
    queues_empty("t4");

    // 5: hold stalls the read of (2,1); second flush ignored while busy
    r0 = reads21;
    done_q.push_back(0);
    start_flush(1'b1);
    n = 0;
    while (!(rd_en && rd_set == 2'd2 && rd_way == 1'b0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reached_2_0", int'(rd_en && rd_set == 2'd2 && rd_way == 1'b0), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold = 1'b1;
    flush_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_rd_en_held", int'(rd_en), 0);
      chk("t5_set", int'(rd_set), 2);
      chk("t5_way", int'(rd_way), 1);
      chk("t5_flush_ready", int'(flush_ready), 0);
    end
    hold = 1'b0;
    flush_valid = 1'b0;
    wait_done(n);
    chk("t5_single_read_2_1", reads21 - r0, 1);
    @(posedge clk); #1;
    chk("t5_idle", int'(busy), 0);
    queues_empty("t5");

    // 6: reset during EVICT
    st_mem[0] = 3'd3;
    evict_ready = 1'b0;
    start_flush(1'b1);
    wait_evict();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_async_evict_valid", int'(evict_valid), 0);
    chk("t6_async_flush_ready", int'(flush_ready), 1);
    @(posedge clk); #1;
    chk("t6_flush_ready", int'(flush_ready), 1);
    chk("t6_busy", int'(busy), 0);
    chk("t6_evict_valid", int'(evict_valid), 0);
    chk("t6_evict_cnt", int'(evict_cnt), 0);
    chk("t6_flush_done", int'(flush_done), 0);
    rst = 1'b1;
    evict_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("t6_still_idle", int'(flush_ready), 1);
    queues_empty("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
